// File: rtl/rx_payload_assembler.sv
// Pulls a little-endian 16-bit word count and then the payload bytes from the RX FIFO,
// and packs them into WORD_BYTES-wide words. Optional idle timeout: RX_PAYLOAD_TIMEOUT_EN.
module rx_payload_assembler #(
    parameter int WORD_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    fifo_empty,
    output logic                    fifo_re,
    input  logic                    fifo_out_valid,
    input  logic [7:0]              fifo_out_data,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [8*WORD_BYTES-1:0] word_data,
    output logic [15:0]             words_left,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_OUT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    outstanding_q, outstanding_d;
    logic [IDX_W-1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]              count_lo_q, count_lo_d;
    logic                    word_valid_q, word_valid_d;
    logic [8*WORD_BYTES-1:0] word_data_q, word_data_d;
    logic [15:0]             words_left_q, words_left_d;

    logic fetching;
    logic retire;
    logic timeout_hit;

    assign fetching = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    assign retire   = outstanding_q & fifo_out_valid;
    // A new read is only launched once the previous one has retired.
    assign fifo_re  = fetching & ~fifo_empty & ~outstanding_q;

`ifdef RX_PAYLOAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            stalled;

    assign stalled     = fetching & fifo_empty & ~outstanding_q;
    assign timeout_hit = stalled && (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!fetching || retire || timeout_hit) begin
            wait_cnt_d = '0;
        end else if (stalled) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        outstanding_d = fifo_re | (outstanding_q & ~fifo_out_valid);
        byte_idx_d    = byte_idx_q;
        count_lo_d    = count_lo_q;
        word_valid_d  = word_valid_q;
        word_data_d   = word_data_q;
        words_left_d  = words_left_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (retire) begin
                    count_lo_d = fifo_out_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (retire) begin
                    words_left_d = {fifo_out_data, count_lo_q};
                    byte_idx_d   = '0;
                    state_d      = ({fifo_out_data, count_lo_q} == 16'd0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (retire) begin
                    for (int k = 0; k < WORD_BYTES; k++) begin
                        if (byte_idx_q == IDX_W'(k)) begin
                            word_data_d[8*k +: 8] = fifo_out_data;
                        end
                    end
                    if (byte_idx_q == LAST_IDX) begin
                        byte_idx_d   = '0;
                        word_valid_d = 1'b1;
                        state_d      = S_OUT;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (word_ready) begin
                    word_valid_d = 1'b0;
                    if (words_left_q != 16'd0) begin
                        words_left_d = words_left_q - 16'd1;
                    end
                    state_d = (words_left_q <= 16'd1) ? S_DONE : S_DATA;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abandon the transfer; whatever is left stays in the FIFO.
        if (timeout_hit) begin
            state_d    = S_IDLE;
            byte_idx_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            outstanding_q <= 1'b0;
            byte_idx_q    <= '0;
            count_lo_q    <= '0;
            word_valid_q  <= 1'b0;
            word_data_q   <= '0;
            words_left_q  <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            byte_idx_q    <= byte_idx_d;
            count_lo_q    <= count_lo_d;
            word_valid_q  <= word_valid_d;
            word_data_q   <= word_data_d;
            words_left_q  <= words_left_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign words_left = words_left_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign error      = timeout_hit;

endmodule

// File: tb/tb_rx_payload_assembler.sv
// Scoreboard bench for rx_payload_assembler: a byte-queue FIFO model feeds the DUT,
// expected words are packed from the payload and popped by a monitor on each handshake.
module tb_rx_payload_assembler;

    localparam int WB = 4;
`ifdef RX_PAYLOAD_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 2700000;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          fifo_empty;
    logic          fifo_re;
    logic          fifo_out_valid = 1'b0;
    logic [7:0]    fifo_out_data = 8'h00;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic [8*WB-1:0] word_data;
    logic [15:0]   words_left;
    logic          busy;
    logic          done;
    logic          error;

    rx_payload_assembler #(.WORD_BYTES(WB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
        .fifo_out_valid(fifo_out_valid), .fifo_out_data(fifo_out_data),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .words_left(words_left), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // FIFO model: one byte per fifo_re, data valid the following cycle
    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_re && !fifo_empty) begin
            fifo_out_data  <= mem[rd_ptr[7:0]];
            rd_ptr         <= rd_ptr + 1;
            fifo_out_valid <= 1'b1;
        end else begin
            fifo_out_valid <= 1'b0;
        end
    end

    // Consumer: 0 = always ready, 1 = random, 2 = hold off 20 cycles after valid rises
    int ready_mode = 0;
    int hold = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: word_ready = 1'b1;
            1: word_ready = 1'($urandom_range(0, 1));
            default: begin
                if (!word_valid) begin
                    hold = 0;
                    word_ready = 1'b0;
                end else if (hold < 20) begin
                    hold++;
                    word_ready = 1'b0;
                end else begin
                    word_ready = 1'b1;
                end
            end
        endcase
    end

    typedef struct {
        logic [8*WB-1:0] data;
        logic [15:0]     left;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    byte unsigned pay_q[$];

    int errors = 0;
    int checks = 0;
    int re_cnt = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    int last_stall = 0;
    bit zero_txn = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_done = 1'b0;
    logic prev_hs = 1'b0;
    logic [8*WB-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            prev_hs    = 1'b0;
            stall_cnt  = 0;
        end else begin
            if (fifo_re) begin
                re_cnt++;
                check("re_while_empty", fifo_empty, 0);
            end
            if (word_valid) check("re_during_out", fifo_re, 0);
            if (prev_stall) begin
                check("valid_held", word_valid, 1);
                check("data_held", word_data, prev_data);
            end
            if (prev_done) check("busy_after_done", busy, 0);
            if (word_valid && word_ready) begin
                last_stall = stall_cnt;
                stall_cnt  = 0;
                if (exp_q.size() == 0) begin
                    check("word_expected", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", word_data, mon_e.data);
                    check("words_left", words_left, mon_e.left);
                end
            end else if (word_valid) begin
                stall_cnt++;
            end
            if (done) begin
                done_cnt++;
                check("done_all_words", exp_q.size(), 0);
                if (!zero_txn) check("done_after_hs", prev_hs, 1);
                check("done_no_error", error, 0);
            end
            prev_stall = word_valid && !word_ready;
            prev_data  = word_data;
            prev_done  = done;
            prev_hs    = word_valid && word_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    // Reference: word w holds payload bytes w*WB .. w*WB+WB-1, byte k at bit 8k.
    task automatic run_txn(input int cnt, input int gap, input bit extra_start);
        logic [63:0] word;
        logic [15:0] c16;
        int re0;
        int d0;
        zero_txn = (cnt == 0);
        for (int w = 0; w < cnt; w++) begin
            word = 64'd0;
            for (int k = 0; k < WB; k++) word = word + (64'(pay_q[w*WB+k]) << (8*k));
            exp_q.push_back('{word[8*WB-1:0], 16'(cnt - w)});
        end
        re0 = re_cnt;
        d0  = done_cnt;
        c16 = 16'(cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
        push_byte(c16[7:0]);
        push_byte(c16[15:8]);
        for (int i = 0; i < pay_q.size(); i++) begin
            if (extra_start && i == 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            repeat (gap) tick();
            push_byte(pay_q[i]);
        end
        for (int t = 0; t < 5000 && done_cnt == d0; t++) tick();
        check("done_pulse", done_cnt - d0, 1);
        tick();
        check("fifo_reads", re_cnt - re0, 2 + cnt*WB);
        check("words_left_end", words_left, 0);
        check("busy_end", busy, 0);
        check("words_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fifo_re"}, fifo_re, 0);
        check({tag, "_word_valid"}, word_valid, 0);
        check({tag, "_word_data"}, word_data, 0);
        check({tag, "_words_left"}, words_left, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        int gap;
        int n;
        int d0;

        tick();
        tick();
        check_reset_outputs("rst_init");
        rst = 1'b1;
        tick();

        // count 2, always ready
        ready_mode = 0;
        pay_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_txn(2, 0, 1'b0);

        // count 0
        pay_q.delete();
        run_txn(0, 0, 1'b0);

        // backpressure
        ready_mode = 2;
        pay_q = {8'h11, 8'h22, 8'h33, 8'h44};
        run_txn(1, 0, 1'b0);
        check("bp_stall_cycles", last_stall, 20);
        ready_mode = 0;

        // FIFO gaps plus a stray start while busy
        pay_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_txn(2, 7, 1'b1);

        // reset after two payload bytes
        start = 1'b1;
        tick();
        start = 1'b0;
        push_byte(8'h01);
        push_byte(8'h00);
        push_byte(8'h11);
        push_byte(8'h22);
        for (int t = 0; t < 100 && rd_ptr != wr_ptr; t++) tick();
        tick();
        tick();
        check("pre_reset_busy", busy, 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        tick();
        rst = 1'b1;
        tick();
        pay_q = {8'h55, 8'h66, 8'h77, 8'h88};
        run_txn(1, 0, 1'b0);

        // randomized transactions
        ready_mode = 1;
        for (int r = 0; r < 12; r++) begin
            cnt = int'($urandom_range(1, 5));
            gap = int'($urandom_range(0, 3));
            pay_q.delete();
            for (int i = 0; i < cnt*WB; i++) pay_q.push_back(8'($urandom_range(0, 255)));
            run_txn(cnt, gap, 1'b0);
        end
        ready_mode = 0;

`ifdef RX_PAYLOAD_TIMEOUT_EN
        // timeout: count 1, only two payload bytes ever arrive
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        push_byte(8'h01);
        push_byte(8'h00);
        push_byte(8'h11);
        push_byte(8'h22);
        n = 0;
        while (!(fifo_out_valid && rd_ptr == wr_ptr) && n < 200) begin
            tick();
            n++;
        end
        n = 0;
        while (!error && n < 500) begin
            tick();
            n++;
        end
        check("timeout_latency", n, TO);
        tick();
        check("timeout_idle", busy, 0);
        check("timeout_no_done", done_cnt - d0, 0);
`else
        n = 0;
        d0 = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
